// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpu_pkg
// Purpose  : Types and constants shared by the per-lane units of a GPU core
//            (register file, ALU, LSU, PC unit).
// Contents : core_state_t     - core pipeline phase encoding (all 8 codes used)
//            reg_input_mux_t  - register write-back source select
//            REG_*_IDX        - indices of the read-only identity registers
//            NUM_WRITABLE_REGS- count of general-purpose registers (R0-R12)
// Revision : 1.0 - initial release
// ============================================================================
package gpu_pkg;

  typedef enum logic [2:0] {
    CS_IDLE    = 3'b000,
    CS_FETCH   = 3'b001,
    CS_DECODE  = 3'b010,
    CS_REQUEST = 3'b011,
    CS_WAIT    = 3'b100,
    CS_EXECUTE = 3'b101,
    CS_UPDATE  = 3'b110,
    CS_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [1:0] {
    MUX_ALU  = 2'b00,
    MUX_LSU  = 2'b01,
    MUX_IMM  = 2'b10,
    MUX_RSVD = 2'b11
  } reg_input_mux_t;

  localparam logic [3:0] REG_BLOCK_IDX     = 4'd13;
  localparam logic [3:0] REG_BLOCK_DIM     = 4'd14;
  localparam logic [3:0] REG_THREAD_IDX    = 4'd15;
  localparam int         NUM_WRITABLE_REGS = 13;

endpackage : gpu_pkg
`default_nettype wire

// File: rtl/thread_register_file.sv
`default_nettype none
// ============================================================================
// Module   : thread_register_file
// Purpose  : Sixteen-entry register file for one GPU thread lane. R0-R12 are
//            general purpose, R13 mirrors the block index, R14 returns the
//            block dimension and R15 the lane's thread index.
// Ports    : clk, reset (async, active-high), enable (lane active)
//            block_id                 - mirrored into R13 every enabled edge
//            core_state               - core phase; reads in REQUEST, writes
//                                       in UPDATE
//            decoded_rd/rs/rt_address - destination / operand indices
//            decoded_reg_write_enable - instruction writes rd
//            decoded_reg_input_mux    - write source (ALU/LSU/IMM/reserved)
//            decoded_immediate, alu_out, lsu_out - write-back data sources
//            rs, rt                   - registered operands for the ALU
// Revision : 1.0 - initial release
// ============================================================================
module thread_register_file
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rd_address,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt
);

  logic [DATA_BITS-1:0] gpr_q [NUM_WRITABLE_REGS];
  logic [DATA_BITS-1:0] block_idx_q;
  logic [DATA_BITS-1:0] rs_q, rs_d;
  logic [DATA_BITS-1:0] rt_q, rt_d;
  logic [DATA_BITS-1:0] wr_data_d;
  logic                 wr_en_d;
  logic [DATA_BITS-1:0] reg_view [16];

  // Architectural view of all 16 registers; R13 is taken from the register
  // (pre-edge value), so a same-cycle mirror update is not visible to reads.
  always_comb begin
    for (int i = 0; i < NUM_WRITABLE_REGS; i++) begin
      reg_view[i] = gpr_q[i];
    end
    reg_view[REG_BLOCK_IDX]  = block_idx_q;
    reg_view[REG_BLOCK_DIM]  = DATA_BITS'(THREADS_PER_BLOCK);
    reg_view[REG_THREAD_IDX] = DATA_BITS'(THREAD_ID);
  end

  // Operand latch: hold unless this is an enabled REQUEST cycle.
  always_comb begin
    rs_d = rs_q;
    rt_d = rt_q;
    if (enable && (core_state == CS_REQUEST)) begin
      rs_d = reg_view[decoded_rs_address];
      rt_d = reg_view[decoded_rt_address];
    end
  end

  // Write-back select and protection decode. Destinations at or above R13
  // and the reserved mux code simply produce no write.
  always_comb begin
    wr_data_d = alu_out;
    wr_en_d   = enable && (core_state == CS_UPDATE) && decoded_reg_write_enable &&
                (decoded_rd_address < 4'(NUM_WRITABLE_REGS));
    case (reg_input_mux_t'(decoded_reg_input_mux))
      MUX_ALU:  wr_data_d = alu_out;
      MUX_LSU:  wr_data_d = lsu_out;
      MUX_IMM:  wr_data_d = decoded_immediate;
      default:  wr_en_d   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WRITABLE_REGS; i++) begin
        gpr_q[i] <= '0;
      end
      block_idx_q <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
    end else if (enable) begin
      block_idx_q <= DATA_BITS'(block_id);
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      if (wr_en_d) begin
        gpr_q[decoded_rd_address] <= wr_data_d;
      end
    end
  end

  assign rs = rs_q;
  assign rt = rt_q;

endmodule : thread_register_file
`default_nettype wire

// File: tb/tb_thread_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_thread_register_file
// Purpose  : Self-checking bench for thread_register_file. Stimulus walks
//            instructions through the core phases and pushes expected
//            operand pairs into a queue from an array model of the sixteen
//            registers; a monitor pops on every enabled REQUEST edge and
//            checks that rs/rt hold between requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_thread_register_file;

  localparam int TPB = 4;
  localparam int TID = 2;
  localparam int DB  = 8;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_REQ = 3'd3, ST_WAIT = 3'd4,
                         ST_EXEC = 3'd5, ST_UPD = 3'd6;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [7:0]    block_id;
  logic [2:0]    core_state;
  logic [3:0]    rd_a, rs_a, rt_a;
  logic          we;
  logic [1:0]    mux;
  logic [DB-1:0] imm, alu, lsu;
  logic [DB-1:0] rs, rt;

  always #5 clk = ~clk;

  thread_register_file #(
    .THREADS_PER_BLOCK(TPB),
    .THREAD_ID        (TID),
    .DATA_BITS        (DB)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .block_id                (block_id),
    .core_state              (core_state),
    .decoded_rd_address      (rd_a),
    .decoded_rs_address      (rs_a),
    .decoded_rt_address      (rt_a),
    .decoded_reg_write_enable(we),
    .decoded_reg_input_mux   (mux),
    .decoded_immediate       (imm),
    .alu_out                 (alu),
    .lsu_out                 (lsu),
    .rs                      (rs),
    .rt                      (rt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the sixteen architectural registers.
  logic [7:0]  model_r [16];
  logic [15:0] exp_q [$];
  logic [7:0]  hold_rs = '0, hold_rt = '0;
  logic        was_req = 1'b0;

  task automatic model_clear();
    for (int i = 0; i < 14; i++) model_r[i] = '0;
    model_r[14] = 8'(TPB);
    model_r[15] = 8'(TID);
  endtask

  // One clock of stimulus; model effects are applied with the inputs that
  // the DUT samples on the coming edge. Reads use pre-edge register values.
  task automatic step(input logic [2:0] st, input logic en);
    core_state = st;
    enable     = en;
    if (en && st == ST_REQ) exp_q.push_back({model_r[rs_a], model_r[rt_a]});
    if (en && st == ST_UPD && we && rd_a <= 4'd12) begin
      case (mux)
        2'd0: model_r[rd_a] = alu;
        2'd1: model_r[rd_a] = lsu;
        2'd2: model_r[rd_a] = imm;
        default: ;
      endcase
    end
    if (en) model_r[13] = block_id;
    @(posedge clk);
    #1;
  endtask

  // Full instruction; operand addresses are scrambled after REQUEST so the
  // held operands are exercised every time.
  task automatic instr(input logic [3:0] a_rs, input logic [3:0] a_rt,
                       input logic [3:0] a_rd, input logic a_we,
                       input logic [1:0] a_mux, input logic [7:0] a_imm,
                       input logic [7:0] a_alu, input logic [7:0] a_lsu);
    rs_a = a_rs; rt_a = a_rt; rd_a = a_rd; we = a_we; mux = a_mux;
    imm = a_imm; alu = a_alu; lsu = a_lsu;
    step(ST_REQ, 1'b1);
    rs_a = 4'($urandom); rt_a = 4'($urandom);
    step(ST_WAIT, 1'b1);
    rs_a = 4'($urandom); rt_a = 4'($urandom);
    step(ST_EXEC, 1'b1);
    step(ST_UPD, 1'b1);
    step(ST_IDLE, 1'b1);
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (rs !== 8'h00 || rt !== 8'h00) begin
      errors++;
      $display("FAIL async_reset rs=%h rt=%h required 00 00", rs, rt);
    end
    model_clear();
    #1;
    reset = 1'b0;
  endtask

  // Reset flushes outstanding expectations; the outputs clear to zero.
  always @(posedge reset) begin
    exp_q.delete();
    hold_rs = '0;
    hold_rt = '0;
    was_req = 1'b0;
  end

  // Monitor: pop on every enabled REQUEST edge, compare every cycle.
  initial begin
    forever begin
      @(posedge clk);
      was_req = (core_state == ST_REQ) && enable && !reset;
      @(negedge clk);
      if (was_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow queue empty, required an entry");
        end else begin
          {hold_rs, hold_rt} = exp_q.pop_front();
        end
      end
      checks++;
      if (rs !== hold_rs || rt !== hold_rt) begin
        errors++;
        $display("FAIL operands t=%0t rs=%h rt=%h required rs=%h rt=%h",
                 $time, rs, rt, hold_rs, hold_rt);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; block_id = 8'd0; core_state = ST_IDLE;
    rd_a = '0; rs_a = '0; rt_a = '0; we = 1'b0; mux = '0;
    imm = '0; alu = '0; lsu = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rs !== 8'h00 || rt !== 8'h00) begin
      errors++;
      $display("FAIL reset_state rs=%h rt=%h required 00 00", rs, rt);
    end
    reset = 1'b0;

    // CONST then ADD loopback
    instr(4'd0, 4'd12, 4'd1, 1'b1, 2'b10, 8'd10, 8'd0, 8'd0);
    instr(4'd0, 4'd12, 4'd2, 1'b1, 2'b10, 8'd20, 8'd0, 8'd0);
    instr(4'd1, 4'd2,  4'd3, 1'b1, 2'b00, 8'd0,  8'd30, 8'd0);
    instr(4'd3, 4'd1,  4'd0, 1'b0, 2'b00, 8'd0,  8'd0, 8'd0);
    // LSU write, then reserved mux leaves R12 untouched
    instr(4'd0, 4'd0,  4'd12, 1'b1, 2'b01, 8'd0, 8'd0, 8'hA5);
    instr(4'd12, 4'd3, 4'd12, 1'b1, 2'b11, 8'h11, 8'h22, 8'h33);
    instr(4'd12, 4'd12, 4'd0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);
    // Protected registers
    block_id = 8'd7;
    instr(4'd0, 4'd0, 4'd13, 1'b1, 2'b10, 8'hFF, 8'hFF, 8'hFF);
    instr(4'd0, 4'd0, 4'd14, 1'b1, 2'b00, 8'hFF, 8'hFF, 8'hFF);
    instr(4'd0, 4'd0, 4'd15, 1'b1, 2'b01, 8'hFF, 8'hFF, 8'hFF);
    instr(4'd13, 4'd14, 4'd0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);
    instr(4'd15, 4'd15, 4'd0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);
    // R13 read in the same edge as a new block_id mirror
    block_id = 8'd9;
    instr(4'd13, 4'd13, 4'd0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);
    // Enable gating on REQUEST and UPDATE
    rs_a = 4'd3; rt_a = 4'd1;
    step(ST_REQ, 1'b0);
    rd_a = 4'd4; we = 1'b1; mux = 2'b10; imm = 8'h5C;
    step(ST_UPD, 1'b0);
    we = 1'b0;
    step(ST_IDLE, 1'b1);
    instr(4'd4, 4'd3, 4'd0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);
    // Reset mid-cycle with non-zero operands latched
    instr(4'd1, 4'd2, 4'd0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);
    async_reset();
    instr(4'd0, 4'd12, 4'd0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);
    instr(4'd1, 4'd13, 4'd0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);

    // Randomized phase: arbitrary states, enables and data
    for (int n = 0; n < 600; n++) begin
      rs_a = 4'($urandom); rt_a = 4'($urandom); rd_a = 4'($urandom);
      we = 1'($urandom); mux = 2'($urandom);
      imm = 8'($urandom); alu = 8'($urandom); lsu = 8'($urandom);
      if ($urandom_range(0, 9) == 0) block_id = 8'($urandom);
      if ($urandom_range(0, 99) == 0) async_reset();
      step(3'($urandom), ($urandom_range(0, 4) != 0));
    end
    for (int i = 0; i < 16; i++) begin
      instr(4'(i), 4'(15 - i), 4'd0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0);
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_thread_register_file
`default_nettype wire

// File: doc/thread_register_file.md
# thread_register_file

Per-thread register file for one GPU compute thread: sixteen 8-bit registers, thirteen general-purpose (R0–R12) plus three read-only identity registers (R13 block ID, R14 block dimension, R15 thread ID). It sits directly upstream and downstream of the thread's ALU:

- It supplies the `rs`/`rt` operands during REQUEST.
- It writes back the ALU, LSU or immediate result during UPDATE, as sequenced by the core's `core_state`.

One instance exists per thread lane in each core.

## Interface
Parameters:
- `THREADS_PER_BLOCK`, default 4: constant value returned by R14.
- `THREAD_ID`, default 0: this lane's index, returned by R15.
- `DATA_BITS`, default 8: register and operand width.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; one clock domain.
- `enable`  in  1  lane active. Low means no register or output updates; outputs hold.
- `block_id`  in  8  current block index, mirrored into R13.
- `core_state`  in  3  core phase: IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
- `decoded_rd_address`  in  4  write-back destination.
- `decoded_rs_address`  in  4  first operand index.
- `decoded_rt_address`  in  4  second operand index.
- `decoded_reg_write_enable`  in  1  instruction writes `rd`.
- `decoded_reg_input_mux`  in  2  write source: 00 ALU, 01 LSU, 10 immediate, 11 reserved.
- `decoded_immediate`  in  8  constant for CONST.
- `alu_out`  in  8  ALU result. Arithmetic value, or comparison result with NZP in bits [2:0].
- `lsu_out`  in  8  load data.
- `rs`  out  8  registered first operand.
- `rt`  out  8  registered second operand.

## Operation
- Reset (async assert): R0–R12 = 0, R13 = 0, `rs` = 0, `rt` = 0. R14 and R15 are constants and are unaffected.
- R13 mirroring: R13 loads `block_id` on every rising edge while `enable`=1. This is independent of `core_state`.
- Operand read: in REQUEST with `enable`=1, `rs` ← R[`decoded_rs_address`] and `rt` ← R[`decoded_rt_address`]. In all other states `rs`/`rt` hold.
- Write-back: in UPDATE with `enable`=1, `decoded_reg_write_enable`=1 and `decoded_rd_address` ≤ 12, R[rd] is written from the source selected by `decoded_reg_input_mux`:
  - 00 → `alu_out`
  - 01 → `lsu_out`
  - 10 → `decoded_immediate`
  - 11 → no write
- Protected registers: writes addressed to R13–R15 are silently dropped. No error is flagged.
- Same index for both operands: `rs_address` == `rt_address` loads the same value into both outputs.
- Comparison results (`alu_out` with `output_mux`=1) are written back verbatim when requested. NZP capture belongs to the PC unit, not here.
- All arithmetic is pass-through. No width conversion; every data path is `DATA_BITS` wide.

## Timing
- Operand latency: `rs`/`rt` are valid from the edge that ends REQUEST. They hold through WAIT, EXECUTE and UPDATE, so the ALU sees stable inputs in EXECUTE.
- Write latency: R[rd] is updated on the edge that ends UPDATE. The next instruction's REQUEST sees the new value, so no bypass is needed.
- Simultaneous events:
  - Read (REQUEST) and write (UPDATE) are mutually exclusive by state, so no collision is possible.
  - R13 mirroring in the same cycle as an R13 read: the read returns the pre-edge value of R13.
- `enable` low mid-instruction: the current edge performs no read or write. State is preserved and resumes when `enable` returns.
- Reset mid-instruction: all writable state and outputs clear immediately, with no clock required. A pending UPDATE write is lost.
- Undefined `core_state` codes: none exist, because all 8 encodings are named. States other than REQUEST and UPDATE are no-ops apart from R13 mirroring.

## Structure
- Shared package `gpu_pkg` holds:
  - `core_state_t` enum with the 8 encodings above
  - `reg_input_mux_t` (ALU/LSU/IMM/RSVD)
  - constants `REG_BLOCK_IDX`=13, `REG_BLOCK_DIM`=14, `REG_THREAD_IDX`=15, `NUM_WRITABLE_REGS`=13
- The ALU and the other lane units import the same package.
- No sub-module. A single module holds the register array, the write mux, the read latches and the protection decode.

## Test plan
- Reset values: assert `reset` asynchronously mid-cycle → `rs`=`rt`=0 immediately. After release, a REQUEST reading R0/R12 returns 0/0.
- CONST then ADD loopback: UPDATE with mux=10, imm=10 → R1; imm=20 → R2. Then REQUEST rs=1, rt=2 → `rs`=10, `rt`=20. Drive `alu_out`=30 and UPDATE rd=3 mux=00 → a later REQUEST of R3 returns 30.
- LSU write: UPDATE mux=01, `lsu_out`=0xA5, rd=12 → R12 reads 0xA5. Repeat with mux=11 and rd=12 → R12 remains 0xA5.
- Protected registers: `block_id`=7, THREAD_ID=2, THREADS_PER_BLOCK=4. UPDATE writes 0xFF to R13, R14 and R15 → subsequent reads return 7, 4 and 2.
- Enable gating: `enable`=0 during REQUEST with rs=3 → `rs` holds its prior value. `enable`=0 during UPDATE with rd=4 → R4 unchanged.
- Operand stability: after REQUEST latches rs=1, rt=2, change the address inputs during WAIT/EXECUTE/UPDATE → `rs`/`rt` do not change until the next REQUEST.
